// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] rt_data,
  input  logic         mthi,
  input  logic         mtlo,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [N-1:0]   m;        // multiplicand magnitude or divisor magnitude
  logic [N-1:0]   a_raw;    // dividend as latched, returned in HI on divide by zero
  logic           is_div, neg_res, neg_rem, b_zero;

  // Operand decode for launch: signed ops work on magnitudes
  logic         sgn_op, a_neg, b_neg;
  logic [N-1:0] a_abs, b_abs;
  assign sgn_op = ~op[0];
  assign a_neg  = sgn_op & rs_data[N-1];
  assign b_neg  = sgn_op & rt_data[N-1];
  assign a_abs  = a_neg ? (~rs_data + 1'b1) : rs_data;
  assign b_abs  = b_neg ? (~rt_data + 1'b1) : rt_data;

  // One iteration step for each operation
  logic [N:0]     mul_sum, div_sh, div_diff;
  logic           div_ge;
  logic [2*N-1:0] prod_neg;
  logic [N-1:0]   q_fix, r_fix;
  assign mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, m} : '0);
  assign div_sh   = acc[2*N-1:N-1];
  assign div_diff = div_sh - {1'b0, m};
  assign div_ge   = ~div_diff[N];
  assign prod_neg = ~acc + 1'b1;
  assign q_fix    = neg_res ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];
  assign r_fix    = neg_rem ? (~acc[2*N-1:N] + 1'b1) : acc[2*N-1:N];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and busy decode
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand latch, shift-add / restoring-divide steps, HI/LO write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      acc         <= '0;
      m           <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            is_div      <= op[1];
            neg_res     <= a_neg ^ b_neg;
            neg_rem     <= a_neg;
            b_zero      <= (rt_data == '0);
            a_raw       <= rs_data;
            acc         <= op[1] ? {{N{1'b0}}, a_abs} : {{N{1'b0}}, b_abs};
            m           <= op[1] ? b_abs : a_abs;
            div_by_zero <= 1'b0;
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        CALC: begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          if (is_div)
            acc <= {(div_ge ? div_diff[N-1:0] : div_sh[N-1:0]), acc[N-2:0], div_ge};
          else
            acc <= {mul_sum, acc[N-1:1]};
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= neg_res ? prod_neg : acc;
          end else if (b_zero) begin
            hi          <= a_raw;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed scoreboard bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } res_t;

  res_t sb[$];

  mult_div_unit #(.N(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb_, sp;
    logic [63:0] ua, ub, up;
    r.dbz = 1'b0;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: begin sp = sa * sb_; {r.hi, r.lo} = sp; end
      2'b01: begin up = ua * ub; {r.hi, r.lo} = up; end
      default: begin
        if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else if (o == 2'b10) begin
          sp = sa / sb_; r.lo = sp[31:0];
          sp = sa % sb_; r.hi = sp[31:0];
        end else begin
          up = ua / ub; r.lo = up[31:0];
          up = ua % ub; r.hi = up[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Launch one op, disturb inputs while busy, then check latency, hold and result
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic with_move);
    res_t exp;
    logic [31:0] pre_hi, pre_lo;
    int busy_cnt;
    bit hold_ok, seen;
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1; mthi = with_move; mtlo = with_move;
    sb.push_back(model(o, a, b));
    pre_hi = hi; pre_lo = lo;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rs_data = ~a; rt_data = ~b; op = ~o;
    check("dbz_clear_on_start", div_by_zero, 0);
    busy_cnt = 0; hold_ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (hi !== pre_hi || lo !== pre_lo) hold_ok = 1'b0;
        if (i == 5) begin mthi = 1'b1; start = 1'b1; rs_data = 32'hA5A5_A5A5; end
        else begin mthi = 1'b0; start = 1'b0; end
        @(negedge clk);
      end
    end
    check("done_seen", seen, 1);
    check("busy_cycles", busy_cnt, 33);
    check("hilo_hold", hold_ok, 1);
    check("busy_low_at_done", busy, 0);
    exp = sb.pop_front();
    check("hi", hi, exp.hi);
    check("lo", lo, exp.lo);
    check("dbz", div_by_zero, exp.dbz);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);

    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_lo_const", lo, 32'h0000_0001);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);

    do_op(2'b11, 32'h1234_5678, 32'd0, 1'b0);
    check("divu0_hi_const", hi, 32'h1234_5678);
    check("divu0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu0_flag_const", div_by_zero, 1);

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    check("div_ovf_hi_const", hi, 32'h0000_0000);

    do_op(2'b10, 32'h8765_4321, 32'd0, 1'b0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(2'b11, 32'd5, 32'd9, 1'b0);
    for (int k = 0; k < 6; k++)
      do_op(2'(k % 4), $urandom, (k == 3) ? 32'($urandom_range(1, 15)) : $urandom, 1'b0);

    // Moves in idle: one-cycle latency, no done, flag untouched
    @(negedge clk);
    mthi = 1'b1; rs_data = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle_hi", hi, 32'hA5A5_A5A5);
    check("mthi_idle_done", done, 0);
    mtlo = 1'b1; rs_data = 32'h5A5A_0001;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_idle_lo", lo, 32'h5A5A_0001);
    check("mtlo_idle_hi_kept", hi, 32'hA5A5_A5A5);
    mthi = 1'b1; mtlo = 1'b1; rs_data = 32'h0F0F_F0F0;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", hi, 32'h0F0F_F0F0);
    check("mthilo_lo", lo, 32'h0F0F_F0F0);

    // Reset during a divide discards it without a done pulse
    op = 2'b10; rs_data = 32'd1000; rt_data = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);

    do_op(2'b01, 32'd123456, 32'd654321, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
